// File: rtl/spi_master_param.sv
// spi_master_param
//   Full-duplex SPI master with a configurable word width, sclk divider and
//   SPI mode. A word is taken on a start pulse and shifted out MSB-first on
//   mosi while miso is captured. The received word is presented on o_dout
//   together with a one-cycle o_done strobe.
//
// Parameters
//   WIDTH  bits per transfer (2..32)
//   DIV    system clocks per sclk half-period (>= 1)
//   CPOL   sclk idle level
//   CPHA   0: sample on the leading edge, 1: sample on the trailing edge
//
// Ports
//   i_clk      system clock, all logic on posedge
//   i_rst_n    synchronous active-low reset
//   i_start    transfer request, only honoured in IDLE
//   i_din      transmit word, captured on the accept cycle
//   i_miso     serial data from the slave
//   o_dout     last received word
//   o_done     one-cycle completion pulse
//   o_busy     high from the cycle after accept until done
//   o_mosi     serial data to the slave
//   o_sclk     serial clock (registered)
//   o_ss       active-low slave select
//
// Build option
//   SPI_MASTER_LOOPBACK_EN  when defined, the receive path samples the
//                           internal mosi register instead of i_miso.

module spi_master_param #(
    parameter int WIDTH = 8,
    parameter int DIV   = 2,
    parameter bit CPOL  = 1'b0,
    parameter bit CPHA  = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_miso,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_done,
    output logic             o_busy,
    output logic             o_mosi,
    output logic             o_sclk,
    output logic             o_ss
);

    localparam int EW = $clog2(2 * WIDTH);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_tx;
    logic [WIDTH-1:0] r_rx;
    logic [WIDTH-1:0] r_dout;
    logic [EW-1:0]    r_edge;
    logic [DW-1:0]    r_div;
    logic             r_sclk;
    logic             r_mosi;
    logic             r_ss;
    logic             r_busy;
    logic             r_done;

    logic w_rx_bit;
    logic w_div_hit;
    logic w_lead;
    logic w_last;

`ifdef SPI_MASTER_LOOPBACK_EN
    logic w_unused_miso;
    assign w_unused_miso = i_miso;
    assign w_rx_bit      = r_mosi;
`else
    assign w_rx_bit      = i_miso;
`endif

    assign w_div_hit = (r_div == DW'(DIV - 1));
    // Even edge counts are leading edges (first toggle away from CPOL).
    assign w_lead    = ~r_edge[0];
    assign w_last    = (r_edge == EW'(2 * WIDTH - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_tx    <= '0;
            r_rx    <= '0;
            r_dout  <= '0;
            r_edge  <= '0;
            r_div   <= '0;
            r_sclk  <= CPOL;
            r_mosi  <= 1'b0;
            r_ss    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // The done cycle itself is still IDLE; a held start is
                    // taken on the following cycle.
                    if (i_start && !r_done) begin
                        if (CPHA) begin
                            r_tx <= i_din;
                        end else begin
                            // Mode with CPHA=0 must have the MSB on the wire
                            // before the first (sampling) edge.
                            r_mosi <= i_din[WIDTH-1];
                            r_tx   <= i_din << 1;
                        end
                        r_rx    <= '0;
                        r_edge  <= '0;
                        r_div   <= '0;
                        r_ss    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (w_div_hit) begin
                        r_div  <= '0;
                        r_sclk <= ~r_sclk;
                        r_edge <= r_edge + EW'(1);
                        if (w_lead) begin
                            if (CPHA) begin
                                r_mosi <= r_tx[WIDTH-1];
                                r_tx   <= r_tx << 1;
                            end else begin
                                r_rx <= {r_rx[WIDTH-2:0], w_rx_bit};
                            end
                        end else begin
                            if (CPHA) begin
                                r_rx <= {r_rx[WIDTH-2:0], w_rx_bit};
                            end else if (!w_last) begin
                                r_mosi <= r_tx[WIDTH-1];
                                r_tx   <= r_tx << 1;
                            end
                        end
                        if (w_last) r_state <= HOLD;
                    end else begin
                        r_div <= r_div + DW'(1);
                    end
                end

                HOLD: begin
                    if (w_div_hit) begin
                        r_div   <= '0;
                        r_ss    <= 1'b1;
                        r_busy  <= 1'b0;
                        r_dout  <= r_rx;
                        r_done  <= 1'b1;
                        r_mosi  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_div <= r_div + DW'(1);
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_dout = r_dout;
    assign o_done = r_done;
    assign o_busy = r_busy;
    assign o_mosi = r_mosi;
    assign o_sclk = r_sclk;
    assign o_ss   = r_ss;

endmodule

// File: tb/tb_spi_master_param.sv
module tb_spi_master_param;

    typedef struct {
        logic [31:0] dout;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [31:0] rxexp(input logic [31:0] d, input logic [31:0] s);
`ifdef SPI_MASTER_LOOPBACK_EN
        return d;
`else
        return s;
`endif
    endfunction

    // ---------------- DUT 0: mode 0, WIDTH 8, DIV 2
    logic       rst0, st0, miso0, done0, busy0, mosi0, sclk0, ss0;
    logic [7:0] din0, dout0;
    spi_master_param #(.WIDTH(8), .DIV(2), .CPOL(1'b0), .CPHA(1'b0)) u0 (
        .i_clk(clk), .i_rst_n(rst0), .i_start(st0), .i_din(din0), .i_miso(miso0),
        .o_dout(dout0), .o_done(done0), .o_busy(busy0), .o_mosi(mosi0),
        .o_sclk(sclk0), .o_ss(ss0));

    // ---------------- DUT 3: mode 3, WIDTH 8, DIV 2
    logic       rst3, st3, miso3, done3, busy3, mosi3, sclk3, ss3;
    logic [7:0] din3, dout3;
    spi_master_param #(.WIDTH(8), .DIV(2), .CPOL(1'b1), .CPHA(1'b1)) u3 (
        .i_clk(clk), .i_rst_n(rst3), .i_start(st3), .i_din(din3), .i_miso(miso3),
        .o_dout(dout3), .o_done(done3), .o_busy(busy3), .o_mosi(mosi3),
        .o_sclk(sclk3), .o_ss(ss3));

    // ---------------- DUT 16: mode 0, WIDTH 16, DIV 1
    logic        rst16, st16, miso16, done16, busy16, mosi16, sclk16, ss16;
    logic [15:0] din16, dout16;
    spi_master_param #(.WIDTH(16), .DIV(1), .CPOL(1'b0), .CPHA(1'b0)) u16 (
        .i_clk(clk), .i_rst_n(rst16), .i_start(st16), .i_din(din16), .i_miso(miso16),
        .o_dout(dout16), .o_done(done16), .o_busy(busy16), .o_mosi(mosi16),
        .o_sclk(sclk16), .o_ss(ss16));

    // ---------------- slave models
    logic [7:0]  sw0, ssh0, sw3, ssh3;
    logic [15:0] sw16, ssh16;

    // CPHA=0 slave: first bit out at ss fall, next bit after each trailing edge
    always @(negedge ss0) begin miso0 = sw0[7]; ssh0 = sw0 << 1; end
    always @(negedge sclk0) if (ss0 === 1'b0) begin miso0 = ssh0[7]; ssh0 = ssh0 << 1; end

    always @(negedge ss16) begin miso16 = sw16[15]; ssh16 = sw16 << 1; end
    always @(negedge sclk16) if (ss16 === 1'b0) begin miso16 = ssh16[15]; ssh16 = ssh16 << 1; end

    // CPOL=1/CPHA=1 slave: new bit on each leading (falling) edge
    always @(negedge ss3) ssh3 = sw3;
    always @(negedge sclk3) if (ss3 === 1'b0) begin miso3 = ssh3[7]; ssh3 = ssh3 << 1; end

    // ---------------- mosi observers
    logic [7:0] cap0, cap3;
    logic       sclk0p = 1'b0, ss0p = 1'b1, sclk3p = 1'b1, ss3p = 1'b1, mosi3p = 1'b0;
    int         viol3 = 0;

    always @(negedge clk) begin
        if (ss0p && !ss0) cap0 <= 8'h00;
        else if (ss0 === 1'b0 && !sclk0p && sclk0) cap0 <= {cap0[6:0], mosi0};
        sclk0p <= sclk0;
        ss0p   <= ss0;
    end

    always @(negedge clk) begin
        if (ss3p && !ss3) cap3 <= 8'h00;
        else if (ss3 === 1'b0 && !sclk3p && sclk3) cap3 <= {cap3[6:0], mosi3};
        // mosi may only move together with a falling sclk while selected
        if (ss3 === 1'b0 && ss3p === 1'b0 && mosi3 !== mosi3p && !(sclk3p && !sclk3))
            viol3 <= viol3 + 1;
        sclk3p <= sclk3;
        ss3p   <= ss3;
        mosi3p <= mosi3;
    end

    // ---------------- scoreboards
    exp_t q0[$], q3[$], q16[$];
    int   dn0 = 0, dn3 = 0, dn16 = 0;

    always @(negedge clk) begin : mon0
        exp_t e;
        if (done0 === 1'b1) begin
            dn0++;
            if (q0.size() == 0) chk("u0 unexpected done", 32'd1, 32'd0);
            else begin
                e = q0.pop_front();
                chk("u0 dout", {24'd0, dout0}, e.dout);
                chk("u0 done cycle", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin : mon3
        exp_t e;
        if (done3 === 1'b1) begin
            dn3++;
            if (q3.size() == 0) chk("u3 unexpected done", 32'd1, 32'd0);
            else begin
                e = q3.pop_front();
                chk("u3 dout", {24'd0, dout3}, e.dout);
                chk("u3 done cycle", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin : mon16
        exp_t e;
        if (done16 === 1'b1) begin
            dn16++;
            if (q16.size() == 0) chk("u16 unexpected done", 32'd1, 32'd0);
            else begin
                e = q16.pop_front();
                chk("u16 dout", {16'd0, dout16}, e.dout);
                chk("u16 done cycle", cyc, e.cyc);
            end
        end
    end

    // ---------------- stimulus helpers (called at a negedge = cycle 0)
    task automatic go0(input logic [7:0] d, input logic [7:0] s, input bit push);
        sw0 = s; st0 = 1'b1; din0 = d;
        if (push) q0.push_back('{dout: rxexp({24'd0, d}, {24'd0, s}), cyc: cyc + 35});
        @(negedge clk);
        st0 = 1'b0;
    endtask

    task automatic go3(input logic [7:0] d, input logic [7:0] s);
        sw3 = s; st3 = 1'b1; din3 = d;
        q3.push_back('{dout: rxexp({24'd0, d}, {24'd0, s}), cyc: cyc + 35});
        @(negedge clk);
        st3 = 1'b0;
    endtask

    initial begin
        int bad;
        int d0;
        rst0 = 1'b0; rst3 = 1'b0; rst16 = 1'b0;
        st0 = 1'b0; st3 = 1'b0; st16 = 1'b0;
        din0 = '0; din3 = '0; din16 = '0;
        miso0 = 1'b0; miso3 = 1'b0; miso16 = 1'b0;
        sw0 = 8'h3C; sw3 = 8'hFF; sw16 = 16'h1234;
        ssh0 = '0; ssh3 = '0; ssh16 = '0;
        cap0 = '0; cap3 = '0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst u0 ss",   ss0,   1'b1);
        chk("rst u0 sclk", sclk0, 1'b0);
        chk("rst u0 mosi", mosi0, 1'b0);
        chk("rst u0 busy", busy0, 1'b0);
        chk("rst u0 done", done0, 1'b0);
        chk("rst u0 dout", dout0, 8'h00);
        chk("rst u3 sclk", sclk3, 1'b1);
        chk("rst u3 ss",   ss3,   1'b1);
        chk("rst u16 dout", dout16, 16'h0000);
        rst0 = 1'b1; rst3 = 1'b1; rst16 = 1'b1;
        repeat (2) @(negedge clk);

        // mode 0: din A5, slave 3C; ss and busy low/high for cycles 1..34
        go0(8'hA5, 8'h3C, 1'b1);
        bad = 0;
        for (int r = 1; r <= 36; r++) begin
            if (ss0 !== (r > 34)) bad++;
            if (busy0 !== (r <= 34)) bad++;
            @(negedge clk);
        end
        chk("u0 ss/busy window", bad, 0);
        chk("u0 mosi on leading edges", cap0, 8'hA5);

        // mode 3: sclk idles high, mosi moves only on falling edges
        chk("u3 sclk idle", sclk3, 1'b1);
        go3(8'h81, 8'hFF);
        repeat (40) @(negedge clk);
        chk("u3 mosi on rising edges", cap3, 8'h81);
        chk("u3 sclk idle after", sclk3, 1'b1);
        go3(8'h3C, 8'hA6);
        repeat (40) @(negedge clk);
        chk("u3 mosi word 2", cap3, 8'h3C);
        chk("u3 mosi edge violations", viol3, 0);

        // WIDTH 16, DIV 1: done at cycle 34
        st16 = 1'b1; din16 = 16'hBEEF;
        q16.push_back('{dout: rxexp(32'h0000BEEF, {16'd0, sw16}), cyc: cyc + 34});
        @(negedge clk);
        st16 = 1'b0;
        repeat (40) @(negedge clk);

        // second start at cycle 10 is ignored
        d0 = dn0;
        go0(8'hC3, 8'h5A, 1'b1);
        repeat (9) @(negedge clk);
        st0 = 1'b1; din0 = 8'h55;
        @(negedge clk);
        st0 = 1'b0;
        repeat (45) @(negedge clk);
        chk("u0 ignored start: done count", dn0 - d0, 1);
        chk("u0 ignored start: tx word", cap0, 8'hC3);

        // reset at cycle 12 of a transfer
        d0 = dn0;
        go0(8'hE7, 8'h11, 1'b0);
        repeat (11) @(negedge clk);
        rst0 = 1'b0;
        @(negedge clk);
        chk("mid-rst ss",   ss0,   1'b1);
        chk("mid-rst sclk", sclk0, 1'b0);
        chk("mid-rst busy", busy0, 1'b0);
        chk("mid-rst dout", dout0, 8'h00);
        chk("mid-rst mosi", mosi0, 1'b0);
        rst0 = 1'b1;
        repeat (40) @(negedge clk);
        chk("mid-rst no done", dn0 - d0, 0);
        go0(8'h0F, 8'h96, 1'b1);
        repeat (40) @(negedge clk);
        chk("post-rst tx word", cap0, 8'h0F);

        // start held high for 100 cycles: accepts at 0, 36, 72
        d0 = dn0;
        sw0 = 8'h3C; din0 = 8'h69; st0 = 1'b1;
        for (int k = 0; k < 3; k++)
            q0.push_back('{dout: rxexp(32'h69, 32'h3C), cyc: cyc + 35 + 36 * k});
        repeat (100) @(negedge clk);
        st0 = 1'b0;
        repeat (20) @(negedge clk);
        chk("held start: done count", dn0 - d0, 3);

        chk("u0 queue drained",  q0.size(),  0);
        chk("u3 queue drained",  q3.size(),  0);
        chk("u16 queue drained", q16.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
